// File: rtl/prod_accumulator.sv
// rtl/prod_accumulator.sv - sums LEN consecutive unsigned products into one held dot-product result
module prod_accumulator #(
    parameter  int M     = 4,
    parameter  int N     = 4,
    parameter  int LEN   = 4,
    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1,
    localparam int ACC_W = M + N + CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             prod_valid,
    output logic             prod_ready,
    input  logic [M+N-1:0]   prod,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic [ACC_W-1:0] acc,
    output logic [CNT_W-1:0] term_cnt
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               acc_valid_q;

    logic               xfer;
    logic               last_term;
    logic [ACC_W-1:0]   acc_d;
    logic [CNT_W-1:0]   cnt_d;

    assign prod_ready = (state_q == ACCUM);
    assign xfer       = prod_valid & prod_ready;
    assign last_term  = (cnt_q == CNT_W'(LEN - 1));
    assign acc_d      = acc_q + ACC_W'(prod);
    assign cnt_d      = cnt_q + CNT_W'(1);

    // clear has priority over both a same-cycle product transfer and a result acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            acc_valid_q <= 1'b0;
        end else if (clear) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            acc_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (xfer) begin
                        acc_q <= acc_d;
                        if (last_term) begin
                            cnt_q       <= '0;
                            state_q     <= HOLD;
                            acc_valid_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                HOLD: begin
                    if (acc_ready) begin
                        acc_q       <= '0;
                        state_q     <= ACCUM;
                        acc_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ACCUM;
                    acc_q       <= '0;
                    cnt_q       <= '0;
                    acc_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign acc       = acc_q;
    assign term_cnt  = cnt_q;
    assign acc_valid = acc_valid_q;

endmodule

// File: tb/tb_prod_accumulator.sv
// tb/tb_prod_accumulator.sv - directed and scoreboarded checks of prod_accumulator
module tb_prod_accumulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       prod_valid;
    logic       prod_ready;
    logic [7:0] prod;
    logic       acc_valid;
    logic       acc_ready;
    logic [9:0] acc;
    logic [1:0] term_cnt;

    int n_checks = 0;
    int n_errors = 0;

    prod_accumulator #(.M(4), .N(4), .LEN(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .prod       (prod),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready),
        .acc        (acc),
        .term_cnt   (term_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] p);
        prod_valid = 1'b1;
        prod       = p;
        cyc();
        prod_valid = 1'b0;
    endtask

    initial begin
        int ready_low;
        int n_prod;
        int n_res;
        int m_cnt;
        int m_sum;
        bit m_hold;
        bit v;
        bit r;
        logic [7:0] p;

        rst_n = 1'b0; clear = 1'b0; prod_valid = 1'b0; prod = '0; acc_ready = 1'b0;
        cyc(); cyc();
        chk("rst_acc", acc, 0);
        chk("rst_cnt", term_cnt, 0);
        chk("rst_valid", acc_valid, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", prod_ready, 1);

        // 1: async reset mid-sum
        send(8'd20); send(8'd30);
        chk("pre_rst_cnt", term_cnt, 2);
        chk("pre_rst_acc", acc, 50);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_acc", acc, 0);
        chk("async_rst_cnt", term_cnt, 0);
        chk("async_rst_valid", acc_valid, 0);
        cyc();
        rst_n = 1'b1;
        #1;
        chk("rel_ready", prod_ready, 1);

        // 2: back-to-back 225 x4 with acc_ready high
        acc_ready = 1'b1;
        prod_valid = 1'b1; prod = 8'd225;
        for (int i = 0; i < 4; i++) begin
            chk("b2b_ready", prod_ready, 1);
            cyc();
        end
        chk("b2b_valid", acc_valid, 1);
        chk("b2b_acc", acc, 900);
        ready_low = 0;
        for (int i = 0; i < 3; i++) begin
            if (!prod_ready) ready_low++;
            cyc();
        end
        prod_valid = 1'b0;
        chk("b2b_bubble", ready_low, 1);
        chk("b2b_after_valid", acc_valid, 0);
        chk("b2b_after_cnt", term_cnt, 2);
        chk("b2b_after_acc", acc, 450);
        acc_ready = 1'b0;
        send(8'd0); send(8'd0);
        acc_ready = 1'b1; cyc(); acc_ready = 1'b0;
        chk("b2b_drain_valid", acc_valid, 0);

        // 3: gaps and backpressure
        send(8'd3); cyc();
        chk("gap_cnt", term_cnt, 1);
        chk("gap_acc", acc, 3);
        send(8'd0); cyc(); cyc();
        chk("gap_cnt2", term_cnt, 2);
        send(8'd7); send(8'd10);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", acc_valid, 1);
            chk("bp_acc", acc, 20);
            chk("bp_ready", prod_ready, 0);
            prod_valid = 1'b1; prod = 8'd77;
            cyc();
        end
        prod_valid = 1'b0;
        acc_ready = 1'b1; cyc(); acc_ready = 1'b0;
        chk("bp_accept_valid", acc_valid, 0);
        chk("bp_accept_acc", acc, 0);
        chk("bp_accept_cnt", term_cnt, 0);

        // 4: clear overriding a transfer
        send(8'd50); send(8'd60);
        clear = 1'b1; send(8'd99); clear = 1'b0;
        chk("clr_acc", acc, 0);
        chk("clr_cnt", term_cnt, 0);
        chk("clr_valid", acc_valid, 0);
        for (int i = 0; i < 4; i++) send(8'd10);
        chk("clr_next_acc", acc, 40);
        chk("clr_next_valid", acc_valid, 1);

        // 5: clear in HOLD with acc_ready; and clear in HOLD without acc_ready
        clear = 1'b1; acc_ready = 1'b1; cyc(); clear = 1'b0; acc_ready = 1'b0;
        chk("clrhold_valid", acc_valid, 0);
        chk("clrhold_ready", prod_ready, 1);
        chk("clrhold_acc", acc, 0);
        for (int i = 0; i < 4; i++) send(8'd5);
        chk("clrhold2_pre", acc, 20);
        clear = 1'b1; cyc(); clear = 1'b0;
        chk("clrhold2_valid", acc_valid, 0);
        chk("clrhold2_ready", prod_ready, 1);
        chk("clrhold2_acc", acc, 0);

        // 6: random traffic against a scoreboard
        n_prod = 0; n_res = 0; m_cnt = 0; m_sum = 0; m_hold = 0;
        for (int c = 0; c < 20000 && n_res < 250; c++) begin
            v = ($urandom_range(3, 0) != 0) && (n_prod < 1000);
            r = ($urandom_range(2, 0) != 0);
            p = 8'($urandom_range(15, 0) * $urandom_range(15, 0));
            prod_valid = v; prod = p; acc_ready = r;
            chk("rnd_ready", prod_ready, !m_hold);
            if (m_hold) chk("rnd_hold_acc", acc, m_sum);
            if (!m_hold && v) begin
                m_sum += p; m_cnt++; n_prod++;
                if (m_cnt == 4) begin m_hold = 1; m_cnt = 0; end
            end else if (m_hold && r) begin
                m_hold = 0; m_sum = 0; n_res++;
            end
            cyc();
            chk("rnd_valid", acc_valid, m_hold);
            chk("rnd_cnt", term_cnt, m_cnt);
        end
        prod_valid = 1'b0; acc_ready = 1'b0;
        chk("rnd_prods", n_prod, 1000);
        chk("rnd_results", n_res, 250);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
